// File: rtl/ppu_framebuffer_banks.sv
// ppu_framebuffer_banks: one framebuffer bank per render core, pipelined
// scanout read port, hardware clear engine and sticky out-of-range flags.
module ppu_framebuffer_banks #(
    parameter int COLOR_WIDTH   = 16,
    parameter int SCREEN_X_SIZE = 800,
    parameter int SCREEN_Y_SIZE = 600,
    parameter int CORES_COUNT   = 10,
    parameter int BUFFER_ADDR_W = 32,
    parameter int READ_LATENCY  = 2,
    localparam int BANK_DEPTH =
        (SCREEN_X_SIZE * SCREEN_Y_SIZE + CORES_COUNT - 1) / CORES_COUNT,
    localparam int CNT_W = (BANK_DEPTH > 1) ? $clog2(BANK_DEPTH) : 1,
    localparam int SEL_W = (CORES_COUNT > 1) ? $clog2(CORES_COUNT) : 1
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [CORES_COUNT-1:0][COLOR_WIDTH-1:0]   wdata,
    input  logic [CORES_COUNT-1:0][BUFFER_ADDR_W-1:0] waddress,
    input  logic [CORES_COUNT-1:0]                    wvalid,
    output logic                                      wready,
    input  logic                                      clear_start,
    input  logic [COLOR_WIDTH-1:0]                    clear_color,
    output logic                                      clear_busy,
    output logic                                      clear_done,
    input  logic                                      rreq,
    input  logic [BUFFER_ADDR_W-1:0]                  raddress,
    input  logic [SEL_W-1:0]                          rselect,
    output logic [COLOR_WIDTH-1:0]                    rdata,
    output logic                                      rvalid,
    output logic                                      wr_oob,
    output logic                                      rd_oob
);

    typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

    localparam logic [BUFFER_ADDR_W-1:0] DEPTH_A  = BUFFER_ADDR_W'(BANK_DEPTH);
    localparam logic [CNT_W-1:0]         CNT_LAST = CNT_W'(BANK_DEPTH - 1);

    state_t                   state;
    state_t                   state_nx;
    logic [CNT_W-1:0]         cnt;
    logic [COLOR_WIDTH-1:0]   clr_color;
    logic                     start_ok;
    logic                     clr_we;
    logic [CORES_COUNT-1:0]   w_hit;
    logic [CORES_COUNT-1:0]   w_bad;
    logic [COLOR_WIDTH-1:0]   bank_q [CORES_COUNT];
    logic [CNT_W-1:0]         rd_idx;
    logic                     rsel_ok;
    logic                     raddr_ok;
    logic                     rd_bad;
    logic [COLOR_WIDTH-1:0]   rd_word;
    logic                     pv [READ_LATENCY];
    logic [COLOR_WIDTH-1:0]   pd [READ_LATENCY];

    assign start_ok   = (state == IDLE) && clear_start;
    assign clr_we     = (state == CLEAR);
    assign wready     = (state == IDLE) && !reset;
    assign clear_busy = (state != IDLE);
    assign clear_done = (state == DONE);

    // Clear sequencer next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (clear_start) state_nx = CLEAR;
            CLEAR:   if (cnt == CNT_LAST) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Clear sequencer state, fill address counter and latched colour
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            clr_color <= '0;
        end else begin
            state <= state_nx;
            if (start_ok) begin
                cnt       <= '0;
                clr_color <= clear_color;
            end else if (clr_we && cnt != CNT_LAST) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign rd_idx = raddress[CNT_W-1:0];

    for (genvar i = 0; i < CORES_COUNT; i++) begin : g_bank
        logic [COLOR_WIDTH-1:0] mem [BANK_DEPTH];

        assign w_hit[i] = wready && wvalid[i] && (waddress[i] < DEPTH_A);
        assign w_bad[i] = wready && wvalid[i] && (waddress[i] >= DEPTH_A);

        // Bank write: the clear engine owns the bank while it runs
        always_ff @(posedge clk) begin
            if (clr_we) begin
                mem[cnt] <= clr_color;
            end else if (w_hit[i]) begin
                mem[waddress[i][CNT_W-1:0]] <= wdata[i];
            end
        end

        assign bank_q[i] = mem[rd_idx];
    end

    assign rsel_ok  = 32'(rselect) < CORES_COUNT;
    assign raddr_ok = raddress < DEPTH_A;
    assign rd_bad   = rreq && !(rsel_ok && raddr_ok);
    assign rd_word  = (rsel_ok && raddr_ok) ? bank_q[rselect] : '0;

    // Read pipe: data only advances behind a valid, so the output holds
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < READ_LATENCY; k++) begin
                pv[k] <= 1'b0;
                pd[k] <= '0;
            end
        end else begin
            pv[0] <= rreq;
            if (rreq) pd[0] <= rd_word;
            for (int k = 1; k < READ_LATENCY; k++) begin
                pv[k] <= pv[k-1];
                if (pv[k-1]) pd[k] <= pd[k-1];
            end
        end
    end

    assign rvalid = pv[READ_LATENCY-1];
    assign rdata  = pd[READ_LATENCY-1];

    // Sticky range-error flags, cleared by reset or a new clear
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_oob <= 1'b0;
            rd_oob <= 1'b0;
        end else begin
            if (start_ok) begin
                wr_oob <= 1'b0;
                rd_oob <= 1'b0;
            end
            if (|w_bad) wr_oob <= 1'b1;
            if (rd_bad) rd_oob <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ppu_framebuffer_banks.sv
// tb_ppu_framebuffer_banks: random and directed traffic against a
// array/queue model of the banked framebuffer (reduced screen size).
module tb_ppu_framebuffer_banks;

    localparam int CW  = 16;
    localparam int XS  = 80;
    localparam int YS  = 60;
    localparam int C   = 10;
    localparam int AW  = 32;
    localparam int LAT = 2;
    localparam int D   = (XS * YS + C - 1) / C;
    localparam int SW  = 4;

    logic                   clk;
    logic                   reset;
    logic [C-1:0][CW-1:0]   wdata;
    logic [C-1:0][AW-1:0]   waddress;
    logic [C-1:0]           wvalid;
    logic                   wready;
    logic                   clear_start;
    logic [CW-1:0]          clear_color;
    logic                   clear_busy;
    logic                   clear_done;
    logic                   rreq;
    logic [AW-1:0]          raddress;
    logic [SW-1:0]          rselect;
    logic [CW-1:0]          rdata;
    logic                   rvalid;
    logic                   wr_oob;
    logic                   rd_oob;

    ppu_framebuffer_banks #(
        .COLOR_WIDTH   (CW),
        .SCREEN_X_SIZE (XS),
        .SCREEN_Y_SIZE (YS),
        .CORES_COUNT   (C),
        .BUFFER_ADDR_W (AW),
        .READ_LATENCY  (LAT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wdata       (wdata),
        .waddress    (waddress),
        .wvalid      (wvalid),
        .wready      (wready),
        .clear_start (clear_start),
        .clear_color (clear_color),
        .clear_busy  (clear_busy),
        .clear_done  (clear_done),
        .rreq        (rreq),
        .raddress    (raddress),
        .rselect     (rselect),
        .rdata       (rdata),
        .rvalid      (rvalid),
        .wr_oob      (wr_oob),
        .rd_oob      (rd_oob)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int            due;
        logic [CW-1:0] d;
    } rd_t;

    int            n_cmp;
    int            n_bad;
    int            cyc;
    logic [CW-1:0] model [C][D];
    rd_t           exp_q [$];
    logic [CW-1:0] cap [$];
    logic          idle_m;
    logic          m_wr_oob;
    logic          m_rd_oob;
    logic [CW-1:0] m_rdata;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    // Apply this cycle's inputs to the model, clock once, check outputs
    task automatic step();
        logic ev;
        if (reset) begin
            exp_q.delete();
            m_wr_oob = 1'b0;
            m_rd_oob = 1'b0;
            m_rdata  = '0;
        end else begin
            if (clear_start && idle_m) begin
                m_wr_oob = 1'b0;
                m_rd_oob = 1'b0;
            end
            if (rreq) begin
                rd_t r;
                r.due = cyc + LAT;
                if (rselect < C && raddress < D) begin
                    r.d = model[rselect][raddress];
                end else begin
                    r.d = '0;
                    m_rd_oob = 1'b1;
                end
                exp_q.push_back(r);
            end
            if (idle_m) begin
                for (int i = 0; i < C; i++) begin
                    if (wvalid[i]) begin
                        if (waddress[i] < D) model[i][waddress[i]] = wdata[i];
                        else m_wr_oob = 1'b1;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        ev = (exp_q.size() > 0) && (exp_q[0].due == cyc);
        if (ev) begin
            m_rdata = exp_q[0].d;
            exp_q.pop_front();
            cap.push_back(rdata);
        end
        chk("rvalid", rvalid, ev);
        chk("rdata", rdata, m_rdata);
        chk("wr_oob", wr_oob, m_wr_oob);
        chk("rd_oob", rd_oob, m_rd_oob);
    endtask

    task automatic quiet();
        wvalid      = '0;
        rreq        = 1'b0;
        clear_start = 1'b0;
    endtask

    task automatic do_clear(input logic [CW-1:0] color);
        int busy_n;
        int done_n;
        int wr_n;
        int done_at;
        quiet();
        clear_start = 1'b1;
        clear_color = color;
        step();
        clear_start = 1'b0;
        for (int b = 0; b < C; b++)
            for (int a = 0; a < D; a++) model[b][a] = color;
        idle_m  = 1'b0;
        busy_n  = 0;
        done_n  = 0;
        wr_n    = 0;
        done_at = -1;
        for (int k = 1; k <= D + 1; k++) begin
            busy_n += int'(clear_busy);
            done_n += int'(clear_done);
            wr_n   += int'(wready);
            if (clear_done) done_at = k;
            wvalid = C'($urandom);
            for (int i = 0; i < C; i++) begin
                waddress[i] = AW'($urandom_range(0, D - 1));
                wdata[i]    = CW'($urandom);
            end
            step();
        end
        wvalid = '0;
        idle_m = 1'b1;
        chk("clr_busy_cycles", busy_n, D + 1);
        chk("clr_done_count", done_n, 1);
        chk("clr_done_pos", done_at, D + 1);
        chk("clr_wready_low", wr_n, 0);
        chk("clr_busy_end", clear_busy, 0);
        chk("clr_wready_end", wready, 1);
    endtask

    task automatic read_wait();
        rreq = 1'b0;
        for (int k = 0; k < LAT; k++) step();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        cyc   = 0;
        idle_m = 1'b0;
        m_wr_oob = 1'b0;
        m_rd_oob = 1'b0;
        m_rdata  = '0;
        wdata = '0;
        waddress = '0;
        raddress = '0;
        rselect = '0;
        clear_color = '0;
        quiet();
        reset = 1'b1;
        step();
        step();
        chk("rst_wready", wready, 0);
        chk("rst_busy", clear_busy, 0);
        chk("rst_done", clear_done, 0);
        reset = 1'b0;
        idle_m = 1'b1;
        #1;
        chk("wready_up", wready, 1);

        // all cores write the same address in one cycle
        for (int i = 0; i < C; i++) begin
            wdata[i]    = CW'(16'h1000 + i);
            waddress[i] = 5;
        end
        wvalid = '1;
        step();
        wvalid   = '0;
        rreq     = 1'b1;
        rselect  = 3;
        raddress = 5;
        step();
        rreq = 1'b0;
        chk("t1_lat1", rvalid, 0);
        step();
        chk("t1_lat2", rvalid, 1);
        chk("t1_data", rdata, 16'h1003);

        // back-to-back reads
        cap.delete();
        rreq = 1'b1;
        for (int k = 0; k < 8; k++) begin
            rselect  = SW'(k);
            raddress = 5;
            step();
        end
        read_wait();
        chk("t2_count", cap.size(), 8);
        for (int k = 0; k < 8 && k < cap.size(); k++)
            chk("t2_order", cap[k], 16'h1000 + k);

        // read-before-write in the same cycle
        wvalid[2]   = 1'b1;
        waddress[2] = 7;
        wdata[2]    = 16'h5555;
        step();
        cap.delete();
        wdata[2] = 16'hAAAA;
        rreq     = 1'b1;
        rselect  = 2;
        raddress = 7;
        step();
        wvalid = '0;
        step();
        read_wait();
        chk("t5_old", cap.size() > 0 ? cap[0] : 16'h0, 16'h5555);
        chk("t5_new", cap.size() > 1 ? cap[1] : 16'h0, 16'hAAAA);

        // full clear
        do_clear(16'hF81F);
        cap.delete();
        rreq = 1'b1;
        for (int b = 0; b < C; b++) begin
            rselect  = SW'(b);
            raddress = 0;
            step();
            raddress = D - 1;
            step();
        end
        for (int k = 0; k < 20; k++) begin
            rselect  = SW'($urandom_range(0, C - 1));
            raddress = AW'($urandom_range(0, D - 1));
            step();
        end
        read_wait();
        chk("t3_count", cap.size(), 2 * C + 20);
        foreach (cap[k]) chk("t3_color", cap[k], 16'hF81F);

        // out-of-range write and read
        wvalid[0]   = 1'b1;
        waddress[0] = D;
        wdata[0]    = 16'h1234;
        step();
        wvalid = '0;
        chk("t4_wr_oob", wr_oob, 1);
        cap.delete();
        rreq     = 1'b1;
        rselect  = 12;
        raddress = 0;
        step();
        rselect  = 0;
        raddress = 0;
        step();
        read_wait();
        chk("t4_rd_zero", cap.size() > 0 ? cap[0] : 16'hFFFF, 0);
        chk("t4_rd_oob", rd_oob, 1);
        chk("t4_unchanged", cap.size() > 1 ? cap[1] : 16'h0, 16'hF81F);
        do_clear(16'h07E0);
        chk("t4_wr_clr", wr_oob, 0);
        chk("t4_rd_clr", rd_oob, 0);

        // reset in the middle of a clear
        quiet();
        clear_start = 1'b1;
        clear_color = 16'h001F;
        step();
        clear_start = 1'b0;
        idle_m = 1'b0;
        for (int k = 0; k < 100; k++) step();
        chk("t6_busy_mid", clear_busy, 1);
        reset = 1'b1;
        step();
        chk("t6_busy", clear_busy, 0);
        chk("t6_done", clear_done, 0);
        reset = 1'b0;
        idle_m = 1'b1;
        step();
        chk("t6_done_after", clear_done, 0);
        chk("t6_wready", wready, 1);
        do_clear(16'h1234);

        // random traffic
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_clear(CW'($urandom));
                continue;
            end
            wvalid = C'($urandom);
            for (int i = 0; i < C; i++) begin
                waddress[i] = ($urandom_range(0, 15) == 0) ?
                    AW'(D + $urandom_range(0, 100)) :
                    AW'($urandom_range(0, D - 1));
                wdata[i] = CW'($urandom);
            end
            rreq     = 1'($urandom);
            rselect  = ($urandom_range(0, 15) == 0) ?
                SW'($urandom_range(C, 15)) : SW'($urandom_range(0, C - 1));
            raddress = ($urandom_range(0, 15) == 0) ?
                AW'(D + $urandom_range(0, 100)) :
                AW'($urandom_range(0, D - 1));
            step();
        end
        quiet();
        read_wait();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
